sweep_datapath: RTL and testbench
=================================

SWEEP_DATAPATH -- requirements
Module: sweep_datapath

Interface
REQ-001 Parameter XMAX, default 159: last x coordinate of the sweep.
REQ-002 Parameter YMAX, default 119: last y coordinate of the sweep.
REQ-003 Parameter XW, default 8: x counter and output width; 2^XW > XMAX.
REQ-004 Parameter YW, default 7: y counter and output width; 2^YW > YMAX.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 resetb  in  1  asynchronous, active-low reset.
REQ-007 initx  in  1  clear x counter to 0.
REQ-008 inity  in  1  clear y counter to 0.
REQ-009 loadx  in  1  advance x counter.
REQ-010 loady  in  1  advance y counter.
REQ-011 plot  in  1  request a pixel write at the current (x,y).
REQ-012 colour  in  3  requested pixel colour.
REQ-013 xdone  out  1  x counter equals XMAX.
REQ-014 ydone  out  1  y counter equals YMAX.
REQ-015 vga_x  out  XW  registered pixel x.
REQ-016 vga_y  out  YW  registered pixel y.
REQ-017 vga_colour  out  3  registered pixel colour.
REQ-018 vga_plot  out  1  registered pixel write strobe.
REQ-019 frame_done  out  1  one-cycle pulse, last pixel of a frame written.
REQ-020 frame_count  out  8  number of completed frames, wraps 255->0.

Function
REQ-021 x counter: initx=1 -> 0; else loadx=1 and x<XMAX -> x+1; else loadx=1 and x==XMAX -> hold XMAX; else hold.
REQ-022 y counter: inity=1 -> 0; else loady=1 and y<YMAX -> y+1; else loady=1 and y==YMAX -> hold YMAX; else hold.
REQ-023 initx has priority over loadx and inity over loady when both are asserted in the same cycle.
REQ-024 x and y update independently; initx with loady in one cycle clears x and advances y.
REQ-025 xdone and ydone are combinational compares of the current counter registers, no added latency.
REQ-026 Pixel stage, one cycle latency: on each edge vga_x<=x, vga_y<=y, vga_plot<=plot, vga_colour<=selected colour (REQ-034/035), all sampled before the counter update of that edge.
REQ-027 vga_x/vga_y/vga_colour hold their last value while vga_plot=0.
REQ-028 frame_done asserts in the cycle after plot=1 is sampled with x==XMAX and y==YMAX, aligned with the corresponding vga_plot.
REQ-029 frame_done is one cycle wide, even if plot stays high at (XMAX,YMAX) for several cycles; rearms only after a cycle without plot=1 at (XMAX,YMAX).
REQ-030 frame_count increments in the same edge that sets frame_done; wraps modulo 256.
REQ-031 Counters saturate and never exceed XMAX/YMAX; no wrap-around to 0 without initx/inity.

Reset
REQ-032 resetb=0 asynchronously forces x=0, y=0, vga_x=0, vga_y=0, vga_colour=0, vga_plot=0, frame_done=0, frame_count=0, frame_done rearm flag to armed.
REQ-033 Reset mid-sweep abandons the frame; no frame_done is produced for it, and operation resumes from (0,0) on the first edge after release.

Configuration
REQ-034 Macro SWEEP_COLOUR_BAR_EN defined: vga_colour = x[4:2] of the sampled x (8-column vertical colour bars); colour input ignored.
REQ-035 Macro SWEEP_COLOUR_BAR_EN undefined: vga_colour = colour input sampled with plot.

Verification
REQ-036 resetb=0 mid-sweep at (37,52) -> all outputs 0 immediately, without waiting for a clock edge; next frame starts at (0,0).
REQ-037 initx=inity=1 for 1 cycle, then loadx=plot=1 for 160 cycles -> vga_x 0..159 one cycle behind x, xdone high when x=159, x holds at 159.
REQ-038 Full sweep driven as controller (initx+loady between rows) -> 19200 vga_plot pulses, exactly one frame_done, frame_count=1.
REQ-039 initx=1 and loadx=1 together at x=20 -> x=0; inity=1 and loady=1 at y=5 -> y=0.
REQ-040 plot held 3 cycles at (159,119) -> single frame_done pulse; 256 frames -> frame_count wraps to 0.
REQ-041 Run with and without SWEEP_COLOUR_BAR_EN, colour=3'b101 -> vga_colour = x[4:2] (e.g. 3'b011 at x=12) vs constant 3'b101.

Source files
------------

// File: rtl/sweep_datapath.sv
// Raster sweep datapath: saturating x/y counters, registered pixel stage,
// frame-completion pulse and frame counter. Optional macro: SWEEP_COLOUR_BAR_EN.
module sweep_datapath #(
  parameter int XMAX = 159,
  parameter int YMAX = 119,
  parameter int XW   = 8,
  parameter int YW   = 7
) (
  input  logic          clk,
  input  logic          resetb,
  input  logic          initx,
  input  logic          inity,
  input  logic          loadx,
  input  logic          loady,
  input  logic          plot,
  input  logic [2:0]    colour,
  output logic          xdone,
  output logic          ydone,
  output logic [XW-1:0] vga_x,
  output logic [YW-1:0] vga_y,
  output logic [2:0]    vga_colour,
  output logic          vga_plot,
  output logic          frame_done,
  output logic [7:0]    frame_count
);

  localparam logic [XW-1:0] XLAST = XW'(XMAX);
  localparam logic [YW-1:0] YLAST = YW'(YMAX);

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          armed;
  logic          last;
  logic [2:0]    pix_colour;

  assign xdone = (x == XLAST);
  assign ydone = (y == YLAST);
  assign last  = plot && xdone && ydone;

`ifdef SWEEP_COLOUR_BAR_EN
  assign pix_colour = x[4:2];
`else
  assign pix_colour = colour;
`endif

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      x <= '0;
      y <= '0;
    end else begin
      if (initx)
        x <= '0;
      else if (loadx && !xdone)
        x <= x + 1'b1;
      if (inity)
        y <= '0;
      else if (loady && !ydone)
        y <= y + 1'b1;
    end
  end

  // Pixel fields only move on a real write so the last pixel stays visible.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
    end else begin
      vga_plot <= plot;
      if (plot) begin
        vga_x      <= x;
        vga_y      <= y;
        vga_colour <= pix_colour;
      end
    end
  end

  // One pulse per stay at the last pixel; rearm once plot leaves it.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      frame_done  <= 1'b0;
      frame_count <= '0;
      armed       <= 1'b1;
    end else begin
      frame_done <= last && armed;
      armed      <= !last;
      if (last && armed)
        frame_count <= frame_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_sweep_datapath.sv
// Self-checking bench for sweep_datapath against a per-cycle
// behavioural model of the counter, pixel and frame rules.
module tb_sweep_datapath;

  localparam int XMAX = 159;
  localparam int YMAX = 119;

  logic       clk = 1'b0;
  logic       resetb = 1'b0;
  logic       initx = 1'b0, inity = 1'b0;
  logic       loadx = 1'b0, loady = 1'b0;
  logic       plot = 1'b0;
  logic [2:0] colour = 3'd0;
  logic       xdone, ydone;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot, frame_done;
  logic [7:0] frame_count;

  sweep_datapath dut (
    .clk(clk), .resetb(resetb),
    .initx(initx), .inity(inity),
    .loadx(loadx), .loady(loady),
    .plot(plot), .colour(colour),
    .xdone(xdone), .ydone(ydone),
    .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .vga_plot(vga_plot),
    .frame_done(frame_done), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state
  int mx, my, ev_x, ev_y, ev_c, ev_p, ef_d, ecount;
  bit marm;

  int plots_seen, frames_seen;

`ifdef SWEEP_COLOUR_BAR_EN
  localparam bit BARS = 1'b1;
`else
  localparam bit BARS = 1'b0;
`endif

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mx = 0; my = 0;
    ev_x = 0; ev_y = 0; ev_c = 0; ev_p = 0;
    ef_d = 0; ecount = 0; marm = 1'b1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".xdone"}, 32'(xdone), 32'(mx == XMAX));
    chk({tag, ".ydone"}, 32'(ydone), 32'(my == YMAX));
    chk({tag, ".vga_x"}, 32'(vga_x), ev_x);
    chk({tag, ".vga_y"}, 32'(vga_y), ev_y);
    chk({tag, ".vga_colour"}, 32'(vga_colour), ev_c);
    chk({tag, ".vga_plot"}, 32'(vga_plot), ev_p);
    chk({tag, ".frame_done"}, 32'(frame_done), ef_d);
    chk({tag, ".frame_count"}, 32'(frame_count), ecount);
  endtask

  // Drive one cycle of inputs, advance the model, check after the edge.
  task automatic step(input string tag, input bit ix, input bit iy,
                      input bit lx, input bit ly, input bit p,
                      input logic [2:0] c);
    bit hit;
    initx = ix; inity = iy; loadx = lx; loady = ly;
    plot = p; colour = c;
    ev_p = p;
    if (p) begin
      ev_x = mx;
      ev_y = my;
      ev_c = BARS ? ((mx / 4) % 8) : int'(c);
    end
    hit = p && mx == XMAX && my == YMAX;
    ef_d = (hit && marm) ? 1 : 0;
    if (ef_d == 1) ecount = (ecount + 1) % 256;
    marm = !hit;
    if (ix) mx = 0;
    else if (lx && mx < XMAX) mx = mx + 1;
    if (iy) my = 0;
    else if (ly && my < YMAX) my = my + 1;
    @(posedge clk);
    #1;
    if (vga_plot) plots_seen++;
    if (frame_done) frames_seen++;
    check_all(tag);
  endtask

  task automatic do_reset();
    resetb = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    #2;
    resetb = 1'b1;
  endtask

  initial begin
    model_reset();
    #3;
    check_all("reset_state");
    resetb = 1'b1;
    @(posedge clk);
    #1;
    check_all("after_release");

    // Row sweep with init
    step("init", 1, 1, 0, 0, 0, 3'd0);
    for (int i = 0; i < 160; i++)
      step("row", 0, 0, 1, 0, 1, 3'($urandom));
    chk("row_vga_x_end", 32'(vga_x), 159);
    chk("row_xdone", 32'(xdone), 1);
    step("row_hold", 0, 0, 1, 0, 0, 3'd0);
    chk("row_x_sat_hold", 32'(xdone), 1);

    // Init priority over load
    step("toy", 1, 1, 0, 0, 0, 3'd0);
    for (int i = 0; i < 20; i++)
      step("to20", 0, 0, 1, (i < 5), 0, 3'd0);
    step("at20", 0, 0, 0, 0, 1, 3'd0);
    chk("at20_x", 32'(vga_x), 20);
    chk("at5_y", 32'(vga_y), 5);
    step("prio", 1, 1, 1, 1, 1, 3'd2);
    step("prio_chk", 0, 0, 0, 0, 1, 3'd2);
    chk("prio_x0", 32'(vga_x), 0);
    chk("prio_y0", 32'(vga_y), 0);

    // Independent x/y: clear x, advance y
    step("ix_ly", 0, 0, 1, 0, 0, 3'd0);
    step("ix_ly2", 1, 0, 0, 1, 0, 3'd0);
    step("ix_ly3", 0, 0, 0, 0, 1, 3'd0);
    chk("indep_x", 32'(vga_x), 0);
    chk("indep_y", 32'(vga_y), 1);

    // Colour at x=12
    step("c_init", 1, 1, 0, 0, 0, 3'd0);
    for (int i = 0; i < 12; i++)
      step("c_walk", 0, 0, 1, 0, 0, 3'd0);
    step("c_plot", 0, 0, 0, 0, 1, 3'b101);
    chk("colour_x12", 32'(vga_colour), BARS ? 3 : 5);

    // Randomized mixed control
    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 15));
      step("rand", (r == 0), (r == 1),
           1'($urandom), 1'($urandom), 1'($urandom),
           3'($urandom));
    end

    // Mid-sweep reset at (37,52)
    step("m_init", 1, 1, 0, 0, 0, 3'd0);
    for (int i = 0; i < 52; i++)
      step("m_y", 0, 0, (i < 37), 1, 0, 3'd0);
    step("m_plot", 0, 0, 0, 0, 1, 3'd6);
    chk("m_vga_x37", 32'(vga_x), 37);
    chk("m_vga_y52", 32'(vga_y), 52);
    do_reset();
    step("m_resume", 0, 0, 0, 0, 1, 3'd1);
    chk("m_resume_x", 32'(vga_x), 0);
    chk("m_resume_y", 32'(vga_y), 0);

    // Full frame as the controller drives it
    do_reset();
    plots_seen = 0;
    frames_seen = 0;
    step("f_init", 1, 1, 0, 0, 0, 3'd0);
    for (int r = 0; r <= YMAX; r++) begin
      for (int c = 0; c <= XMAX; c++)
        step("frame", 0, 0, 1, 0, 1, 3'($urandom));
      if (r != YMAX)
        step("f_next", 1, 0, 0, 1, 0, 3'd0);
    end
    step("f_idle", 0, 0, 0, 0, 0, 3'd0);
    chk("frame_plots", plots_seen, 19200);
    chk("frame_pulses", frames_seen, 1);
    chk("frame_count1", 32'(frame_count), 1);

    // Plot held at the last pixel
    frames_seen = 0;
    for (int i = 0; i < 3; i++)
      step("hold3", 0, 0, 0, 0, 1, 3'd4);
    step("hold_off", 0, 0, 0, 0, 0, 3'd0);
    chk("hold3_pulses", frames_seen, 1);
    chk("frame_count2", 32'(frame_count), 2);

    // Wrap the frame counter
    for (int i = 0; i < 254; i++) begin
      step("wrap_on", 0, 0, 0, 0, 1, 3'd0);
      step("wrap_off", 0, 0, 0, 0, 0, 3'd0);
    end
    chk("frame_count_wrap", 32'(frame_count), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
